exec_mem_unit: RTL and testbench
================================

# exec_mem_unit

Combined execute/memory datapath block for the 16-bit five-stage pipelined CPU. It contains three pieces:
- a main-control decoder for the instruction in ID;
- a 16-bit signed ALU with multiply/divide for the instruction in EX;
- a word-organised data memory for the MEM stage.

All datapath paths are combinational except the memory array. The pipeline registers, forwarding and hazard logic live in the CPU top level.

## Interface
- `DEPTH`, 256 — data-memory size in 16-bit words (power of two).
- `CLOCK`  in  1  — single clock; memory writes occur on the rising edge.
- `RESET`  in  1  — asynchronous, active-high; clears the memory array.
- `dec_op`  in  4  — opcode of the ID-stage instruction (IR[15:12]).
- `dec_func`  in  4  — func field of the ID-stage instruction (IR[3:0]).
- `immd`, `mem_read`, `mem_write`  out  1 each — decoded controls.
- `reg_write`  out  2 — 0 = none, 1 = write rd, 2 = write rd plus R0 (second result).
- `illegal`  out  1 — invalid opcode, or invalid func when opcode is 0.
- `ex_ir`  in  16 — EX-stage instruction.
- `stall`  in  1 — EX bubble; suppresses exception flags.
- `a`, `b`  in  16 signed — forwarded operands.
- `alu_out1`, `alu_out2`  out  16 — primary and secondary results.
- `zero`, `sign`, `overflow`, `div_by_zero`  out  1 each — ALU status flags.
- `mem_addr`  in  16 — byte address.
- `mem_wdata`  in  16 — store data.
- `mem_we`  in  1 — store enable.
- `mem_rdata`  out  16 — load data.

## Operation

**Decoder**

Legal opcodes and their controls:
- Opcode 0 (R-type): func 4/5 → `reg_write` = 2; funcs 0–3 and 8–11 → `reg_write` = 1; any other func → `illegal`.
- Opcode 2 (ADDI): `immd` = 1, `reg_write` = 1.
- Opcode 8 (LW): `immd` = 1, `mem_read` = 1, `reg_write` = 1.
- Opcode 11 (SW): `immd` = 1, `mem_write` = 1.
- Opcodes 4 (BLT), 5 (BGT), 6 (BEQ), 12 (JMP), 15 (HALT): all controls 0.
- Any other opcode: `illegal` = 1, all other controls 0.

**ALU**

R-type functions (`alu_out2` = 0 unless stated):
- func 0: `a` + `b`.
- func 1: `a` − `b`.
- func 2: AND.
- func 3: OR.
- func 4: signed 32-bit product; low half on `alu_out1`, high half on `alu_out2`.
- func 5: signed divide; quotient truncated toward zero on `alu_out1`; remainder (sign of dividend) on `alu_out2`.
- func 8: SLL by `ex_ir[7:4]`.
- func 9: SRL (logical) by `ex_ir[7:4]`.
- func 10: ROL by `ex_ir[7:4]`.
- func 11: ROR by `ex_ir[7:4]`.

Other opcodes:
- ADDI: `a` + sext(`ex_ir[7:0]`).
- LW/SW: `b` + sext(`ex_ir[3:0]`).
- All remaining opcodes: both outputs 0.

Flags:
- `zero` = (`alu_out1` == 0).
- `sign` = `alu_out1[15]`.
- `overflow`: signed overflow on add, sub and ADDI. Also set for −32768 ÷ −1, which yields quotient −32768, remainder 0. Multiply never sets `overflow`.
- `div_by_zero`: divide with `b` == 0; both outputs are then 0.
- `stall` = 1 forces `overflow` and `div_by_zero` to 0; results are still driven.

**Memory**

- Word index = `mem_addr[log2(DEPTH):1]`; bit 0 is ignored.
- Read is combinational.
- An address at or beyond DEPTH words reads 0, and writes to it are ignored.

## Timing
- Decoder and ALU: zero latency, purely combinational.
- Store: `mem_we` sampled at posedge `CLOCK`; the new value is visible on `mem_rdata` after that edge.
- Read/write of the same word in the same cycle: the read returns the old value.
- `RESET` asserted at any time, including mid-write: the array clears to 0 immediately, and no write occurs while `RESET` is high.
- First write is accepted on the first posedge after `RESET` falls.
- Reset values: `mem_rdata` = 0. Every other output depends only on its inputs.

## Configuration
- `EXU_MULDIV_EN` defined: funcs 4 and 5 are implemented as above.
- Not defined: funcs 4 and 5 decode as `illegal` with `reg_write` = 0. The ALU drives 0 on both outputs with no flags, and no multiplier/divider is synthesized.

## Structure
Shared package `exu_pkg`:
- Opcode constants: OP_R, OP_ADDI, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT.
- Func constants.
- `reg_write` encoding.
- NOP constant 16'h2000.

Sub-module: `exu_dmem` holds the memory array. The decoder and ALU stay inline.

## Test plan
- `dec_op`=0, `dec_func`=4 → `reg_write`=2, `illegal`=0; `dec_op`=3 → `illegal`=1, all controls 0.
- Opcode 0, func 0, `a`=16'h7FFF, `b`=1 → `alu_out1`=16'h8000, `overflow`=1, `sign`=1; same inputs with `stall`=1 → `overflow`=0.
- Func 4, `a`=300, `b`=−200 → product −60000: `alu_out1`=16'h15A0, `alu_out2`=16'hFFFF.
- Func 5, `a`=−7, `b`=2 → `alu_out1`=−3, `alu_out2`=−1; `b`=0 → `div_by_zero`=1, both outputs 0.
- SW-style write 16'hBEEF to `mem_addr`=16'h0010, then read the same address → 16'hBEEF; assert `RESET` → `mem_rdata`=0 before the next clock edge.
- Opcode 8, `b`=16'h0020, `ex_ir[3:0]`=4'hE → `alu_out1`=16'h001E.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared opcode, func and control encodings for the execute/memory unit.
package exu_pkg;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd4;
    localparam logic [3:0] OP_BGT  = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_MUL = 4'd4;
    localparam logic [3:0] FN_DIV = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd8;
    localparam logic [3:0] FN_SRL = 4'd9;
    localparam logic [3:0] FN_ROL = 4'd10;
    localparam logic [3:0] FN_ROR = 4'd11;

    typedef enum logic [1:0] {
        RW_NONE  = 2'd0,
        RW_RD    = 2'd1,
        RW_RD_R0 = 2'd2
    } reg_write_e;

    localparam logic [15:0] NOP_INSTR = 16'h2000;

endpackage

// File: rtl/exu_dmem.sv
// Word-organised data memory: combinational read, clocked write, async clear.
module exu_dmem #(
    parameter int DEPTH = 256
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_we,
    output logic [15:0] mem_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [14:0]   word_addr;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          unused_byte_bit;

    // Byte bit 0 is ignored; anything at or past DEPTH words neither reads nor writes.
    assign word_addr       = mem_addr[15:1];
    assign in_range        = (32'(word_addr) < DEPTH);
    assign idx             = word_addr[AW-1:0];
    assign unused_byte_bit = mem_addr[0];

    assign mem_rdata = in_range ? mem_q[idx] : 16'h0000;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (mem_we && in_range) begin
            mem_q[idx] <= mem_wdata;
        end
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory datapath: ID-stage decoder, EX-stage ALU and MEM-stage data memory.
// Define EXU_MULDIV_EN to build the signed multiply (func 4) and divide (func 5).
module exec_mem_unit
    import exu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [3:0]         dec_op,
    input  logic [3:0]         dec_func,
    output logic               immd,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         reg_write,
    output logic               illegal,
    input  logic [15:0]        ex_ir,
    input  logic               stall,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic [15:0]        alu_out1,
    output logic [15:0]        alu_out2,
    output logic               zero,
    output logic               sign,
    output logic               overflow,
    output logic               div_by_zero,
    input  logic [15:0]        mem_addr,
    input  logic [15:0]        mem_wdata,
    input  logic               mem_we,
    output logic [15:0]        mem_rdata
);

    function automatic logic add_ovf(logic [15:0] x, logic [15:0] y, logic [15:0] s);
        return (x[15] == y[15]) && (s[15] != x[15]);
    endfunction

    always_comb begin
        immd      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = RW_NONE;
        illegal   = 1'b0;
        case (dec_op)
            OP_R: begin
                case (dec_func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_SLL, FN_SRL, FN_ROL, FN_ROR: reg_write = RW_RD;
`ifdef EXU_MULDIV_EN
                    FN_MUL, FN_DIV:                 reg_write = RW_RD_R0;
`endif
                    default:                        illegal   = 1'b1;
                endcase
            end
            OP_ADDI: begin
                immd      = 1'b1;
                reg_write = RW_RD;
            end
            OP_LW: begin
                immd      = 1'b1;
                mem_read  = 1'b1;
                reg_write = RW_RD;
            end
            OP_SW: begin
                immd      = 1'b1;
                mem_write = 1'b1;
            end
            OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT: ;
            default: illegal = 1'b1;
        endcase
    end

    logic [3:0]         ex_op;
    logic [3:0]         ex_fn;
    logic [3:0]         shamt;
    logic [15:0]        au;
    logic signed [15:0] imm8;
    logic signed [15:0] imm4;
    logic [15:0]        res1;
    logic [15:0]        res2;
    logic               ovf_raw;
    logic               dbz_raw;
    logic               unused_ir_bits;
`ifdef EXU_MULDIV_EN
    logic signed [31:0] prod;
    assign prod = 32'(a) * 32'(b);
`endif

    assign ex_op          = ex_ir[15:12];
    assign ex_fn          = ex_ir[3:0];
    assign shamt          = ex_ir[7:4];
    assign au             = a;
    assign imm8           = {{8{ex_ir[7]}}, ex_ir[7:0]};
    assign imm4           = {{12{ex_ir[3]}}, ex_ir[3:0]};
    assign unused_ir_bits = ^ex_ir[11:8];

    always_comb begin
        res1    = 16'h0000;
        res2    = 16'h0000;
        ovf_raw = 1'b0;
        dbz_raw = 1'b0;
        case (ex_op)
            OP_R: begin
                case (ex_fn)
                    FN_ADD: begin
                        res1    = a + b;
                        ovf_raw = add_ovf(a, b, res1);
                    end
                    FN_SUB: begin
                        res1    = a - b;
                        ovf_raw = add_ovf(a, ~b, res1);
                    end
                    FN_AND: res1 = a & b;
                    FN_OR:  res1 = a | b;
`ifdef EXU_MULDIV_EN
                    FN_MUL: begin
                        res1 = prod[15:0];
                        res2 = prod[31:16];
                    end
                    FN_DIV: begin
                        // -32768 / -1 has no 16-bit quotient; it wraps and flags overflow.
                        if (b == 16'sd0) begin
                            dbz_raw = 1'b1;
                        end else if (a == -16'sd32768 && b == -16'sd1) begin
                            res1    = 16'h8000;
                            ovf_raw = 1'b1;
                        end else begin
                            res1 = a / b;
                            res2 = a % b;
                        end
                    end
`endif
                    FN_SLL: res1 = au << shamt;
                    FN_SRL: res1 = au >> shamt;
                    FN_ROL: res1 = (au << shamt) | (au >> (5'd16 - {1'b0, shamt}));
                    FN_ROR: res1 = (au >> shamt) | (au << (5'd16 - {1'b0, shamt}));
                    default: ;
                endcase
            end
            OP_ADDI: begin
                res1    = a + imm8;
                ovf_raw = add_ovf(a, imm8, res1);
            end
            OP_LW, OP_SW: res1 = b + imm4;
            default: ;
        endcase
    end

    assign alu_out1    = res1;
    assign alu_out2    = res2;
    assign zero        = (res1 == 16'h0000);
    assign sign        = res1[15];
    assign overflow    = ovf_raw & ~stall;
    assign div_by_zero = dbz_raw & ~stall;

    exu_dmem #(.DEPTH(DEPTH)) u_dmem (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: decoder, ALU functions/flags and data memory.
module tb_exec_mem_unit;

    logic               CLOCK = 1'b0;
    logic               RESET;
    logic [3:0]         dec_op, dec_func;
    logic               immd, mem_read, mem_write, illegal;
    logic [1:0]         reg_write;
    logic [15:0]        ex_ir;
    logic               stall;
    logic signed [15:0] a, b;
    logic [15:0]        alu_out1, alu_out2;
    logic               zero, sign, overflow, div_by_zero;
    logic [15:0]        mem_addr, mem_wdata, mem_rdata;
    logic               mem_we;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLOCK = ~CLOCK;

    exec_mem_unit #(.DEPTH(256)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .dec_op(dec_op), .dec_func(dec_func),
        .immd(immd), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .illegal(illegal), .ex_ir(ex_ir), .stall(stall),
        .a(a), .b(b), .alu_out1(alu_out1), .alu_out2(alu_out2), .zero(zero),
        .sign(sign), .overflow(overflow), .div_by_zero(div_by_zero),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // {immd, mem_read, mem_write, reg_write[1:0], illegal}
    task automatic test_decoder();
        logic [3:0] ops [8]  = '{4'd0, 4'd0, 4'd3, 4'd2, 4'd8, 4'd11, 4'd12, 4'd0};
        logic [3:0] fns [8]  = '{4'd4, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0,  4'd0,  4'd6};
        logic [5:0] exps [8];
        logic [5:0] got;
`ifdef EXU_MULDIV_EN
        exps[0] = 6'b000_10_0;
`else
        exps[0] = 6'b000_00_1;
`endif
        exps[1] = 6'b000_01_0;
        exps[2] = 6'b000_00_1;
        exps[3] = 6'b100_01_0;
        exps[4] = 6'b110_01_0;
        exps[5] = 6'b101_00_0;
        exps[6] = 6'b000_00_0;
        exps[7] = 6'b000_00_1;
        for (int i = 0; i < 8; i++) begin
            dec_op = ops[i]; dec_func = fns[i]; #1;
            got = {immd, mem_read, mem_write, reg_write, illegal};
            n_cmp++;
            if (got !== exps[i]) begin
                n_fail++;
                $display("FAIL decode[%0d] op=%0d func=%0d got=%b want=%b", i, ops[i], fns[i], got, exps[i]);
            end
        end
    endtask

    task automatic test_add_sub();
        ex_ir = 16'h0000; a = 16'sh7FFF; b = 16'sd1; stall = 1'b0; #1;
        n_cmp++; if ({alu_out1, overflow, sign, zero} !== {16'h8000, 3'b110}) begin n_fail++; $display("FAIL add_ovf got=%h ovf=%b sign=%b zero=%b want=8000 1 1 0", alu_out1, overflow, sign, zero); end
        stall = 1'b1; #1;
        n_cmp++; if ({alu_out1, overflow} !== {16'h8000, 1'b0}) begin n_fail++; $display("FAIL add_stall got=%h ovf=%b want=8000 0", alu_out1, overflow); end
        stall = 1'b0;
        ex_ir = 16'h0001; a = -16'sd32768; b = 16'sd1; #1;
        n_cmp++; if ({alu_out1, overflow} !== {16'h7FFF, 1'b1}) begin n_fail++; $display("FAIL sub_ovf got=%h ovf=%b want=7fff 1", alu_out1, overflow); end
        a = 16'sd5; b = 16'sd5; #1;
        n_cmp++; if ({alu_out1, overflow, zero} !== {16'h0000, 2'b01}) begin n_fail++; $display("FAIL sub_zero got=%h ovf=%b zero=%b want=0000 0 1", alu_out1, overflow, zero); end
        ex_ir = 16'h0002; a = 16'sh0F0F; b = 16'sh00FF; #1;
        n_cmp++; if ({alu_out1, alu_out2} !== {16'h000F, 16'h0000}) begin n_fail++; $display("FAIL and got=%h/%h want=000f/0000", alu_out1, alu_out2); end
        ex_ir = 16'h20FF; a = 16'sd0; #1;
        n_cmp++; if ({alu_out1, sign, overflow} !== {16'hFFFF, 2'b10}) begin n_fail++; $display("FAIL addi got=%h sign=%b ovf=%b want=ffff 1 0", alu_out1, sign, overflow); end
        ex_ir = 16'h207F; a = 16'sh7FFF; #1;
        n_cmp++; if ({alu_out1, overflow} !== {16'h807E, 1'b1}) begin n_fail++; $display("FAIL addi_ovf got=%h ovf=%b want=807e 1", alu_out1, overflow); end
    endtask

    task automatic test_muldiv();
        ex_ir = 16'h0004; a = 16'sd300; b = -16'sd200; stall = 1'b0; #1;
`ifdef EXU_MULDIV_EN
        n_cmp++; if ({alu_out1, alu_out2, overflow} !== {16'h15A0, 16'hFFFF, 1'b0}) begin n_fail++; $display("FAIL mul got=%h/%h ovf=%b want=15a0/ffff 0", alu_out1, alu_out2, overflow); end
        ex_ir = 16'h0005; a = -16'sd7; b = 16'sd2; #1;
        n_cmp++; if ({alu_out1, alu_out2, div_by_zero} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin n_fail++; $display("FAIL div got=%h/%h dbz=%b want=fffd/ffff 0", alu_out1, alu_out2, div_by_zero); end
        b = 16'sd0; #1;
        n_cmp++; if ({alu_out1, alu_out2, div_by_zero} !== {16'h0000, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL div0 got=%h/%h dbz=%b want=0000/0000 1", alu_out1, alu_out2, div_by_zero); end
        stall = 1'b1; #1;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div0_stall dbz=%b want=0", div_by_zero); end
        stall = 1'b0; a = -16'sd32768; b = -16'sd1; #1;
        n_cmp++; if ({alu_out1, alu_out2, overflow} !== {16'h8000, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL div_ovf got=%h/%h ovf=%b want=8000/0000 1", alu_out1, alu_out2, overflow); end
`else
        n_cmp++; if ({alu_out1, alu_out2, overflow, div_by_zero} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL mul_off got=%h/%h ovf=%b dbz=%b want=0/0 0 0", alu_out1, alu_out2, overflow, div_by_zero); end
        ex_ir = 16'h0005; b = 16'sd0; #1;
        n_cmp++; if ({alu_out1, alu_out2, overflow, div_by_zero} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL div_off got=%h/%h ovf=%b dbz=%b want=0/0 0 0", alu_out1, alu_out2, overflow, div_by_zero); end
`endif
    endtask

    task automatic test_shift_lw();
        logic [15:0] irs  [5] = '{16'h0048, 16'h0049, 16'h004A, 16'h004B, 16'h0000};
        logic [15:0] exps [5] = '{16'h0010, 16'h0800, 16'h0018, 16'h1800, 16'h8001};
        a = 16'sh8001; b = 16'sd0;
        for (int i = 0; i < 5; i++) begin
            ex_ir = irs[i]; #1;
            n_cmp++;
            if (alu_out1 !== exps[i]) begin n_fail++; $display("FAIL shift[%0d] ir=%h got=%h want=%h", i, irs[i], alu_out1, exps[i]); end
        end
        ex_ir = 16'h800E; b = 16'sh0020; #1;
        n_cmp++; if (alu_out1 !== 16'h001E) begin n_fail++; $display("FAIL lw_addr got=%h want=001e", alu_out1); end
        ex_ir = 16'hC123; #1;
        n_cmp++; if ({alu_out1, alu_out2} !== 32'h0) begin n_fail++; $display("FAIL jmp_zero got=%h/%h want=0/0", alu_out1, alu_out2); end
    endtask

    task automatic test_reset();
        RESET = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010; mem_wdata = 16'h0000;
        @(negedge CLOCK); #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h want=0000", mem_rdata); end
        @(negedge CLOCK); RESET = 1'b0;
    endtask

    task automatic test_memory();
        @(negedge CLOCK); mem_addr = 16'h0010; mem_wdata = 16'hBEEF; mem_we = 1'b1; #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL read_old got=%h want=0000", mem_rdata); end
        @(posedge CLOCK); #1;
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL write_read got=%h want=beef", mem_rdata); end
        @(negedge CLOCK); mem_we = 1'b0; mem_addr = 16'h0011; #1;
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL byte_bit got=%h want=beef", mem_rdata); end
        mem_addr = 16'h0200; mem_wdata = 16'h1234; mem_we = 1'b1;
        @(posedge CLOCK); #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL oob_read got=%h want=0000", mem_rdata); end
        mem_we = 1'b0; mem_addr = 16'h0000; #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL oob_alias got=%h want=0000", mem_rdata); end
        mem_addr = 16'h0010; #1;
        RESET = 1'b1; #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL async_clear got=%h want=0000", mem_rdata); end
    endtask

    task automatic test_reset_write();
        @(negedge CLOCK); RESET = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h5555; mem_we = 1'b1;
        @(posedge CLOCK); #1;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL write_in_reset got=%h want=0000", mem_rdata); end
        @(negedge CLOCK); RESET = 1'b0;
        @(posedge CLOCK); #1;
        n_cmp++; if (mem_rdata !== 16'h5555) begin n_fail++; $display("FAIL first_write got=%h want=5555", mem_rdata); end
        mem_we = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; dec_op = 4'd0; dec_func = 4'd0; ex_ir = 16'h2000; stall = 1'b0;
        a = 16'sd0; b = 16'sd0; mem_addr = 16'h0; mem_wdata = 16'h0; mem_we = 1'b0;
        test_reset();
        test_decoder();
        test_add_sub();
        test_muldiv();
        test_shift_lw();
        test_memory();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
